// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO family: default word and address widths,
// the derived depth, and the pointer type (address bits plus one wrap bit).
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 4;
    localparam int DEPTH     = 2 ** ASIZE_DEF;

    // The extra MSB tells a full FIFO apart from an empty one when the
    // address bits of the two pointers are equal.
    typedef logic [ASIZE_DEF:0] ptr_t;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
// Storage array for the FIFO with a synchronous write port and a registered
// synchronous read port.
//   clk     : clock for both ports
//   rst     : synchronous active-high reset, clears rdata only
//   wclken  : write enable
//   waddr   : write address
//   wdata   : write data
//   rclken  : read enable, loads rdata from raddr
//   raddr   : read address
//   rdata   : registered read data, holds when rclken is low
// ---------------------------------------------------------------------------
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wclken,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rclken,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    logic [DSIZE-1:0] mem [2**ASIZE];

    // Array contents are deliberately not reset; the pointer logic in the
    // parent guarantees only written locations are ever read.
    always_ff @(posedge clk) begin
        if (wclken) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rclken) begin
            rdata <= mem[raddr];
        end
    end

endmodule : fifo_mem

// File: rtl/modport_fifo.sv
// ---------------------------------------------------------------------------
// modport_fifo
// Single-clock synchronous FIFO, DSIZE-bit words, 2**ASIZE deep. Same data
// path and flag behaviour as the dual-clock FIFO, with a single clock.
//   wclk   : sole clock
//   wrst   : synchronous active-high reset
//   wdata  : write data
//   winc   : write request, ignored while wfull
//   wfull  : registered full flag
//   rinc   : read request, ignored while rempty
//   rdata  : registered read data, valid one clock after an accepted read
//   rempty : registered empty flag
// ---------------------------------------------------------------------------
module modport_fifo
    import fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty
);

    logic [ASIZE:0] wptr;
    logic [ASIZE:0] rptr;
    logic [ASIZE:0] wptr_next;
    logic [ASIZE:0] rptr_next;
    logic           wr_en;
    logic           rd_en;

    // The registered flags present at the edge gate the requests, so a full
    // FIFO rejects a simultaneous write and an empty one rejects a read.
    assign wr_en = winc & ~wfull;
    assign rd_en = rinc & ~rempty;

    always_comb begin
        wptr_next = wptr + {{ASIZE{1'b0}}, wr_en};
        rptr_next = rptr + {{ASIZE{1'b0}}, rd_en};
    end

    // Flags come from the next-state pointers so they are already correct
    // right after the edge that changes occupancy.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wptr   <= '0;
            rptr   <= '0;
            wfull  <= 1'b0;
            rempty <= 1'b1;
        end else begin
            wptr   <= wptr_next;
            rptr   <= rptr_next;
            rempty <= (wptr_next == rptr_next);
            wfull  <= (wptr_next[ASIZE] != rptr_next[ASIZE]) &&
                      (wptr_next[ASIZE-1:0] == rptr_next[ASIZE-1:0]);
        end
    end

    fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk    (wclk),
        .rst    (wrst),
        .wclken (wr_en),
        .waddr  (wptr[ASIZE-1:0]),
        .wdata  (wdata),
        .rclken (rd_en),
        .raddr  (rptr[ASIZE-1:0]),
        .rdata  (rdata)
    );

endmodule : modport_fifo

// File: tb/tb_modport_fifo.sv
// ---------------------------------------------------------------------------
// tb_modport_fifo
// Directed plus randomized stimulus for modport_fifo, checked against a
// queue-based model of FIFO behaviour.
// ---------------------------------------------------------------------------
module tb_modport_fifo;

    import fifo_pkg::*;

    logic       wclk;
    logic       wrst;
    logic [7:0] wdata;
    logic       winc;
    logic       wfull;
    logic       rinc;
    logic [7:0] rdata;
    logic       rempty;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: a plain queue of stored words plus the last word read.
    logic [7:0] model_q [$];
    logic [7:0] exp_rdata;
    logic [7:0] next_data;

    modport_fifo #(
        .DSIZE (8),
        .ASIZE (4)
    ) dut (
        .wclk   (wclk),
        .wrst   (wrst),
        .wdata  (wdata),
        .winc   (winc),
        .wfull  (wfull),
        .rinc   (rinc),
        .rdata  (rdata),
        .rempty (rempty)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Drive one cycle of inputs, let the edge happen, then advance the model
    // using the occupancy that existed before the edge.
    task automatic applyStimulus(input logic w, input logic [7:0] d,
                                 input logic r, input logic rst);
        bit rd_ok;
        bit wr_ok;
        winc  = w;
        wdata = d;
        rinc  = r;
        wrst  = rst;
        @(posedge wclk);
        #1;
        if (rst) begin
            model_q.delete();
            exp_rdata = 8'h00;
        end else begin
            rd_ok = r && (model_q.size() > 0);
            wr_ok = w && (model_q.size() < DEPTH);
            if (rd_ok) exp_rdata = model_q.pop_front();
            if (wr_ok) model_q.push_back(d);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic exp_empty;
        logic exp_full;
        exp_empty = (model_q.size() == 0);
        exp_full  = (model_q.size() == DEPTH);
        compared++;
        assert (rdata === exp_rdata) else begin
            mismatched++;
            $error("[TB] FAIL %s rdata observed=%h expected=%h", tag, rdata, exp_rdata);
        end
        compared++;
        assert (rempty === exp_empty) else begin
            mismatched++;
            $error("[TB] FAIL %s rempty observed=%b expected=%b", tag, rempty, exp_empty);
        end
        compared++;
        assert (wfull === exp_full) else begin
            mismatched++;
            $error("[TB] FAIL %s wfull observed=%b expected=%b", tag, wfull, exp_full);
        end
    endtask

    task automatic stepCheck(input logic w, input logic [7:0] d,
                             input logic r, input logic rst, input string tag);
        applyStimulus(w, d, r, rst);
        checkOutput(tag);
    endtask

    initial begin
        winc      = 1'b0;
        rinc      = 1'b0;
        wdata     = 8'h00;
        wrst      = 1'b1;
        exp_rdata = 8'h00;
        next_data = 8'h00;

        // Reset with a write request held: reset must dominate.
        stepCheck(1'b1, 8'hAA, 1'b0, 1'b1, "reset0");
        stepCheck(1'b1, 8'hAA, 1'b0, 1'b1, "reset1");
        stepCheck(1'b0, 8'h00, 1'b1, 1'b0, "reset_read_empty");

        // Fill with 0x00..0x0F, then an ignored write while full.
        for (int i = 0; i < 16; i++) begin
            stepCheck(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        end
        stepCheck(1'b1, 8'hFF, 1'b0, 1'b0, "write_when_full");

        // Drain in order, then an ignored read while empty.
        for (int i = 0; i < 16; i++) begin
            stepCheck(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        end
        stepCheck(1'b0, 8'h00, 1'b1, 1'b0, "read_when_empty");

        // Simultaneous access while full: read wins, write rejected.
        for (int i = 0; i < 16; i++) begin
            stepCheck(1'b1, 8'(i), 1'b0, 1'b0, "refill");
        end
        stepCheck(1'b1, 8'h55, 1'b1, 1'b0, "both_when_full");
        for (int i = 0; i < 15; i++) begin
            stepCheck(1'b0, 8'h00, 1'b1, 1'b0, "drain2");
        end

        // Simultaneous access while empty: write wins, read rejected.
        stepCheck(1'b1, 8'h33, 1'b1, 1'b0, "both_when_empty");
        stepCheck(1'b0, 8'h00, 1'b1, 1'b0, "read_after_empty_both");

        // Interleaved traffic across pointer wrap, occupancy kept within 1..3.
        stepCheck(1'b1, next_data, 1'b0, 1'b0, "wrap_prime"); next_data++;
        stepCheck(1'b1, next_data, 1'b0, 1'b0, "wrap_prime"); next_data++;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: begin
                    stepCheck(1'b1, next_data, 1'b1, 1'b0, "wrap_both");
                    next_data++;
                end
                1: begin
                    stepCheck(1'b1, next_data, 1'b0, 1'b0, "wrap_write");
                    next_data++;
                    stepCheck(1'b0, 8'h00, 1'b1, 1'b0, "wrap_read");
                end
                default: begin
                    stepCheck(1'b0, 8'h00, 1'b1, 1'b0, "wrap_read");
                    stepCheck(1'b1, next_data, 1'b0, 1'b0, "wrap_write");
                    next_data++;
                end
            endcase
        end
        stepCheck(1'b0, 8'h00, 1'b1, 1'b0, "wrap_drain");
        stepCheck(1'b0, 8'h00, 1'b1, 1'b0, "wrap_drain");

        // Reset mid-operation discards stored words.
        for (int i = 0; i < 5; i++) begin
            stepCheck(1'b1, 8'($urandom), 1'b0, 1'b0, "pre_reset_fill");
        end
        stepCheck(1'b0, 8'h00, 1'b0, 1'b1, "mid_reset");
        stepCheck(1'b1, 8'h77, 1'b0, 1'b0, "post_reset_write");
        stepCheck(1'b0, 8'h00, 1'b1, 1'b0, "post_reset_read");

        // Free-running random traffic, biased so the FIFO visits both flags.
        for (int i = 0; i < 400; i++) begin
            logic w;
            logic r;
            if ((i / 100) % 2 == 0) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            stepCheck(w, 8'($urandom), r, 1'b0, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_modport_fifo
